// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the common-data-bus arbiter.
package cdb_arbiter_pkg;

    localparam int XLEN          = 32;
    localparam int TAG_W         = 6;
    localparam int N_REQ_DEFAULT = 3;

    localparam int ARB_MULT = 0;
    localparam int ARB_ALU  = 1;
    localparam int ARB_LOAD = 2;

    typedef logic [TAG_W-1:0] phys_reg_tag_t;

    typedef struct packed {
        phys_reg_tag_t   tag;
        logic [XLEN-1:0] data;
    } cdb_arb_entry_t;

    // Requester index visited at step 'off' of a rotation starting at 'base'.
    function automatic int rr_index(input int base, input int off, input int n);
        int idx;
        idx = base + off;
        if (idx >= n) begin
            idx = idx - n;
        end else begin
            idx = idx;
        end
        return idx;
    endfunction

endpackage

// File: rtl/cdb_arb_fifo.sv
// Per-requester result FIFO; ready is derived from the registered count only.
module cdb_arb_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           flush_i,
    input  logic           push_i,
    input  cdb_arb_entry_t push_entry_i,
    input  logic           pop_i,
    output logic           ready_o,
    output logic           nonempty_o,
    output cdb_arb_entry_t head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    cdb_arb_entry_t   mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_s;
    logic             pop_s;

    assign ready_o    = (count_q < CNT_W'(DEPTH));
    assign nonempty_o = (count_q != {CNT_W{1'b0}});
    assign head_o     = mem_q[rd_ptr_q];
    assign push_s     = push_i & ready_o & ~flush_i;
    assign pop_s      = pop_i & nonempty_o & ~flush_i;

    // Pointer and occupancy next-state; flush empties the FIFO.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; validity is tracked by count_q so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: per-requester FIFOs feeding one broadcast bus.
// Define CDB_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEFAULT,
    parameter int BUF_DEPTH = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [N_REQ-1:0]            req_valid_i,
    input  logic [N_REQ-1:0][TAG_W-1:0] req_tag_i,
    input  logic [N_REQ-1:0][XLEN-1:0]  req_data_i,
    output logic [N_REQ-1:0]            req_ready_o,
    input  logic                        flush_i,
    output logic                        cdb_valid_o,
    output logic [TAG_W-1:0]            cdb_tag_o,
    output logic [XLEN-1:0]             cdb_data_o,
    output logic                        cdb_T_used_o,
    output logic [N_REQ-1:0]            grant_o,
    output logic                        cdb_stall_o
);

    logic [N_REQ-1:0] ready_s;
    logic [N_REQ-1:0] nonempty_s;
    logic [N_REQ-1:0] grant_s;
    cdb_arb_entry_t   push_entry_s [N_REQ];
    cdb_arb_entry_t   head_s       [N_REQ];
    cdb_arb_entry_t   sel_s;
    logic             cdb_valid_s;
    logic             found_s;

    for (genvar g = 0; g < N_REQ; g++) begin : g_fifo
        assign push_entry_s[g] = '{tag: req_tag_i[g], data: req_data_i[g]};

        cdb_arb_fifo #(
            .DEPTH (BUF_DEPTH)
        ) u_fifo (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .flush_i      (flush_i),
            .push_i       (req_valid_i[g]),
            .push_entry_i (push_entry_s[g]),
            .pop_i        (grant_s[g]),
            .ready_o      (ready_s[g]),
            .nonempty_o   (nonempty_s[g]),
            .head_o       (head_s[g])
        );
    end

`ifdef CDB_ARB_ROUND_ROBIN_EN
    localparam int RR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [RR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [RR_W-1:0] win_idx_s;

    // Round-robin pick: first non-empty head at or after rr_ptr_q.
    always_comb begin
        grant_s   = {N_REQ{1'b0}};
        win_idx_s = {RR_W{1'b0}};
        found_s   = 1'b0;
        for (int off = 0; off < N_REQ; off++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!found_s && !flush_i && nonempty_s[i] &&
                    (i == rr_index(int'(rr_ptr_q), off, N_REQ))) begin
                    grant_s[i] = 1'b1;
                    win_idx_s  = RR_W'(i);
                    found_s    = 1'b1;
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

    // Pointer advances past the winner only on an actual broadcast.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (cdb_valid_s) begin
            rr_ptr_d = (win_idx_s == RR_W'(N_REQ - 1)) ? {RR_W{1'b0}} : win_idx_s + RR_W'(1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= {RR_W{1'b0}};
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    // Fixed priority pick: lowest non-empty index wins.
    always_comb begin
        grant_s = {N_REQ{1'b0}};
        found_s = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found_s && !flush_i && nonempty_s[i]) begin
                grant_s[i] = 1'b1;
                found_s    = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end
`endif

    // Broadcast mux from the granted head.
    always_comb begin
        sel_s = '{tag: {TAG_W{1'b0}}, data: {XLEN{1'b0}}};
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_s[i]) begin
                sel_s = head_s[i];
            end else begin
                sel_s = sel_s;
            end
        end
    end

    assign cdb_valid_s  = |grant_s;
    assign cdb_valid_o  = cdb_valid_s;
    assign cdb_tag_o    = sel_s.tag;
    assign cdb_data_o   = sel_s.data;
    assign cdb_T_used_o = cdb_valid_s & (sel_s.tag != {TAG_W{1'b0}});
    assign grant_o      = grant_s;
    assign req_ready_o  = ready_s;
    assign cdb_stall_o  = ~&ready_s;

endmodule
